loop_nest_issue: RTL and testbench

- Issue controller for a two-level pipelined loop nest (outer i, inner j).
- Consumes a one-cycle start pulse from the upstream schedule logic (the count_every_ii_* / signal_seen_first stage).
- Emits one iteration-issue strobe every II cycles with its (i, j) indices to the downstream datapath, then drains the pipeline and pulses done.
- Honours a downstream stall.

---
 rtl/loop_nest_issue.sv | 160 ++++++++++++++++
 tb/tb_loop_nest_issue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_issue.sv
// Issue controller for a two-level pipelined loop nest: issues (i, j) every II cycles, drains, pulses done.
// Optional stall_cycles performance counter is built when LOOP_NEST_ISSUE_PERF_EN is defined.
module loop_nest_issue #(
  parameter int unsigned N_OUTER = 2,
  parameter int unsigned N_INNER = 2,
  parameter int unsigned II      = 1,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  output logic        issue,
  output logic [31:0] i_idx,
  output logic [31:0] j_idx,
  output logic        last,
  output logic        busy,
  output logic        done
`ifdef LOOP_NEST_ISSUE_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ISSUE | issuing iterations every II unstalled cycles
  // S_DRAIN | waiting LATENCY-1 cycles for the datapath to empty
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] OUTER_LAST = 32'(N_OUTER - 1);
  localparam logic [31:0] INNER_LAST = 32'(N_INNER - 1);
  localparam logic [31:0] II_LAST    = 32'(II - 1);
  localparam logic [31:0] DRAIN_LOAD = (LATENCY > 1) ? 32'(LATENCY - 2) : 32'd0;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ii_cnt;
  logic [31:0] i_cnt;
  logic [31:0] j_cnt;
  logic [31:0] drain_cnt;

  logic        accept;
  logic        finish_issue;
  logic        slot_eval;
  logic        fire;
  logic        cur_last;
  logic [31:0] cur_ii;
  logic [31:0] cur_i;
  logic [31:0] cur_j;
  logic [31:0] ii_nxt;
  logic [31:0] i_nxt;
  logic [31:0] j_nxt;
  logic        issue_d;
  logic        last_d;
  logic        done_d;

  assign accept       = (state == S_IDLE) && start;
  assign finish_issue = (state == S_ISSUE) && issue && last;
  // The start edge already evaluates the first slot so the first issue lands one cycle after start.
  assign slot_eval    = accept || ((state == S_ISSUE) && !finish_issue);

  always_comb begin
    cur_ii   = accept ? 32'd0 : ii_cnt;
    cur_i    = accept ? 32'd0 : i_cnt;
    cur_j    = accept ? 32'd0 : j_cnt;
    fire     = slot_eval && !stall && (cur_ii == 32'd0);
    cur_last = (cur_i == OUTER_LAST) && (cur_j == INNER_LAST);
    ii_nxt   = cur_ii;
    i_nxt    = cur_i;
    j_nxt    = cur_j;
    if (slot_eval && !stall) begin
      ii_nxt = (cur_ii == II_LAST) ? 32'd0 : cur_ii + 32'd1;
      if (fire) begin
        if (cur_j == INNER_LAST) begin
          j_nxt = 32'd0;
          i_nxt = cur_i + 32'd1;
        end else begin
          j_nxt = cur_j + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (finish_issue) state_nxt = (LATENCY == 1) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_cnt == 32'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_d = fire;
    last_d  = fire && cur_last;
    done_d  = (state_nxt == S_DONE) && (state != S_DONE);
    busy    = (state == S_ISSUE) || (state == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue     <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
      i_idx     <= 32'd0;
      j_idx     <= 32'd0;
      ii_cnt    <= 32'd0;
      i_cnt     <= 32'd0;
      j_cnt     <= 32'd0;
      drain_cnt <= 32'd0;
    end else begin
      issue <= issue_d;
      last  <= last_d;
      done  <= done_d;
      if (fire) begin
        i_idx <= cur_i;
        j_idx <= cur_j;
      end
      if (state == S_DONE) begin
        ii_cnt <= 32'd0;
        i_cnt  <= 32'd0;
        j_cnt  <= 32'd0;
      end else if (slot_eval) begin
        ii_cnt <= ii_nxt;
        i_cnt  <= i_nxt;
        j_cnt  <= j_nxt;
      end
      if ((state_nxt == S_DRAIN) && (state != S_DRAIN)) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == S_DRAIN) && (drain_cnt != 32'd0)) begin
        drain_cnt <= drain_cnt - 32'd1;
      end
    end
  end

`ifdef LOOP_NEST_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
    end else if (accept) begin
      stall_cycles <= 32'd0;
    end else if ((state == S_ISSUE) && stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_loop_nest_issue.sv
// Randomized bench for loop_nest_issue: four configurations checked cycle by cycle against an issue-slot model.
// Builds with or without LOOP_NEST_ISSUE_PERF_EN.
module tb_loop_nest_issue;

  localparam int MAXC = 128;
  localparam int unsigned CFG_NO  [4] = '{2, 2, 1, 3};
  localparam int unsigned CFG_NI  [4] = '{3, 3, 1, 2};
  localparam int unsigned CFG_II  [4] = '{1, 2, 4, 3};
  localparam int unsigned CFG_LAT [4] = '{3, 3, 1, 2};

  logic        clk;
  logic        rst;
  logic        start_s  [4];
  logic        stall_s  [4];
  logic        issue_s  [4];
  logic [31:0] i_idx_s  [4];
  logic [31:0] j_idx_s  [4];
  logic        last_s   [4];
  logic        busy_s   [4];
  logic        done_s   [4];
`ifdef LOOP_NEST_ISSUE_PERF_EN
  logic [31:0] stall_cycles_s [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    loop_nest_issue #(
      .N_OUTER(CFG_NO[g]),
      .N_INNER(CFG_NI[g]),
      .II     (CFG_II[g]),
      .LATENCY(CFG_LAT[g])
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start_s[g]),
      .stall(stall_s[g]),
      .issue(issue_s[g]),
      .i_idx(i_idx_s[g]),
      .j_idx(j_idx_s[g]),
      .last (last_s[g]),
      .busy (busy_s[g]),
      .done (done_s[g])
`ifdef LOOP_NEST_ISSUE_PERF_EN
      ,
      .stall_cycles(stall_cycles_s[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  bit stall_e   [MAXC];
  bit pulse     [MAXC];
  bit exp_issue [MAXC];
  bit exp_last  [MAXC];
  bit exp_busy  [MAXC];
  bit exp_done  [MAXC];
  int exp_i     [MAXC];
  int exp_j     [MAXC];
  int done_c;
  int exp_stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int t = 0; t < MAXC; t++) begin
      stall_e[t] = 1'b0;
      pulse[t]   = 1'b0;
    end
  endtask

  // stall_e[t] is the stall value sampled at edge t; cycle t follows edge t, start sampled at edge 1.
  task automatic build_model(input int d);
    int no;
    int ni;
    int ii;
    int lat;
    int total;
    int p;
    int k;
    int last_c;
    no = int'(CFG_NO[d]);
    ni = int'(CFG_NI[d]);
    ii = int'(CFG_II[d]);
    lat = int'(CFG_LAT[d]);
    total = no * ni;
    p = 0;
    k = 0;
    last_c = 0;
    for (int t = 0; t < MAXC; t++) begin
      exp_issue[t] = 1'b0;
      exp_last[t]  = 1'b0;
      exp_busy[t]  = 1'b0;
      exp_done[t]  = 1'b0;
      exp_i[t]     = 0;
      exp_j[t]     = 0;
    end
    for (int t = 1; t < MAXC && k < total; t++) begin
      if (!stall_e[t]) begin
        if (p % ii == 0) begin
          exp_issue[t] = 1'b1;
          exp_i[t]     = k / ni;
          exp_j[t]     = k % ni;
          exp_last[t]  = (k == total - 1);
          last_c       = t;
          k++;
        end
        p++;
      end
    end
    done_c = last_c + lat;
    exp_done[done_c] = 1'b1;
    for (int t = 1; t < done_c; t++) exp_busy[t] = 1'b1;
    exp_stalls = 0;
    for (int t = 2; t <= last_c + 1; t++) if (stall_e[t]) exp_stalls++;
  endtask

  task automatic check_cycle(input int d, input int t, input string name);
    chk($sformatf("%s c%0d issue", name, t), 32'(issue_s[d]), 32'(exp_issue[t]));
    chk($sformatf("%s c%0d last", name, t), 32'(last_s[d]), 32'(exp_last[t]));
    chk($sformatf("%s c%0d busy", name, t), 32'(busy_s[d]), 32'(exp_busy[t]));
    chk($sformatf("%s c%0d done", name, t), 32'(done_s[d]), 32'(exp_done[t]));
    if (exp_issue[t]) begin
      chk($sformatf("%s c%0d i_idx", name, t), i_idx_s[d], 32'(exp_i[t]));
      chk($sformatf("%s c%0d j_idx", name, t), j_idx_s[d], 32'(exp_j[t]));
    end
  endtask

  task automatic run_case(input int d, input string name);
    @(posedge clk);
    #1;
    start_s[d] = 1'b1;
    stall_s[d] = stall_e[1];
    for (int t = 1; t <= done_c + 2; t++) begin
      @(posedge clk);
      #1;
      start_s[d] = pulse[t];
      stall_s[d] = stall_e[t + 1];
      @(negedge clk);
      check_cycle(d, t, name);
    end
    start_s[d] = 1'b0;
    stall_s[d] = 1'b0;
`ifdef LOOP_NEST_ISSUE_PERF_EN
    chk($sformatf("%s stall_cycles", name), stall_cycles_s[d], 32'(exp_stalls));
`endif
  endtask

  initial begin
    int d;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      start_s[g] = 1'b0;
      stall_s[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset%0d issue", g), 32'(issue_s[g]), 32'd0);
      chk($sformatf("reset%0d busy", g), 32'(busy_s[g]), 32'd0);
      chk($sformatf("reset%0d done", g), 32'(done_s[g]), 32'd0);
      chk($sformatf("reset%0d i_idx", g), i_idx_s[g], 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);

    clear_stim();
    build_model(0);
    run_case(0, "plan_ii1");

    clear_stim();
    build_model(1);
    run_case(1, "plan_ii2");

    clear_stim();
    stall_e[3] = 1'b1;
    stall_e[4] = 1'b1;
    build_model(0);
    run_case(0, "plan_stall");

    clear_stim();
    build_model(0);
    pulse[4]      = 1'b1;
    pulse[done_c] = 1'b1;
    run_case(0, "plan_restart");

    clear_stim();
    build_model(2);
    run_case(2, "plan_single");

    // asynchronous reset between edges after the third issue, then a clean rerun
    clear_stim();
    build_model(0);
    @(posedge clk);
    #1;
    start_s[0] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      @(negedge clk);
      check_cycle(0, t, "pre_rst");
    end
    #2;
    rst = 1'b0;
    #1;
    chk("midrst issue", 32'(issue_s[0]), 32'd0);
    chk("midrst busy", 32'(busy_s[0]), 32'd0);
    chk("midrst done", 32'(done_s[0]), 32'd0);
    chk("midrst last", 32'(last_s[0]), 32'd0);
    chk("midrst i_idx", i_idx_s[0], 32'd0);
    chk("midrst j_idx", j_idx_s[0], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst busy", 32'(busy_s[0]), 32'd0);
    chk("postrst done", 32'(done_s[0]), 32'd0);
    clear_stim();
    build_model(0);
    run_case(0, "rerun");

    for (int r = 0; r < 12; r++) begin
      d = int'($urandom_range(0, 3));
      clear_stim();
      for (int t = 1; t <= 40; t++) stall_e[t] = ($urandom_range(0, 9) < 3);
      build_model(d);
      for (int t = 1; t <= done_c; t++) pulse[t] = ($urandom_range(0, 9) == 0);
      run_case(d, $sformatf("rnd%0d_cfg%0d", r, d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
